// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the memory bus arbiter: FSM state encoding,
// requester IDs and default bus widths.
package mem_bus_arbiter_pkg;

  localparam int DEF_AW = 16;
  localparam int DEF_DW = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MEM  = 2'd1,
    ST_ACK  = 2'd2
  } arb_state_t;

  typedef enum logic {
    REQ_PQ = 1'b0,
    REQ_XU = 1'b1
  } req_id_t;

endpackage

// File: rtl/mem_arb_watchdog.sv
// Memory-access watchdog: counts cycles while enabled and flags expiry on
// the TIMEOUT-th enabled cycle since the last start/clear.
// Only instantiated when MEM_ARB_TIMEOUT_EN is defined.
module mem_arb_watchdog #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_reg;

  // Cycle counter: zeroed on start/clear, saturates at the last count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (start || clear) begin
      cnt_reg <= '0;
    end else if (enable && (cnt_reg != LAST)) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign expired = enable && (cnt_reg == LAST);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-requester memory bus arbiter (prefetch queue vs. execution unit).
// XU has priority; a starvation counter forces a PQ grant after STARVE_MAX
// consecutive XU grants taken while PQ was waiting. One access in flight,
// all outputs registered.
// Optional build macro MEM_ARB_TIMEOUT_EN adds a watchdog that aborts an
// access after TIMEOUT cycles without mem_rdy (rdata = all ones, err = 1).
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int AW         = DEF_AW,
  parameter int DW         = DEF_DW,
  parameter int STARVE_MAX = 3,
  parameter int TIMEOUT    = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pq_req,
  input  logic [AW-1:0] pq_adr,
  output logic          pq_ack,
  output logic [DW-1:0] pq_rdata,
  output logic          pq_err,
  input  logic          xu_req,
  input  logic          xu_we,
  input  logic [AW-1:0] xu_adr,
  input  logic [DW-1:0] xu_wdata,
  output logic          xu_ack,
  output logic [DW-1:0] xu_rdata,
  output logic          xu_err,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_adr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_rdy,
  input  logic [DW-1:0] mem_rdata
);

  localparam int SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  arb_state_t    state_reg, state_next;
  req_id_t       grant_reg, grant_next;
  logic [SW-1:0] starve_reg, starve_next;
  logic          mem_req_reg, mem_req_next;
  logic          mem_we_reg, mem_we_next;
  logic [AW-1:0] mem_adr_reg, mem_adr_next;
  logic [DW-1:0] mem_wdata_reg, mem_wdata_next;
  logic [DW-1:0] pq_rdata_reg, pq_rdata_next;
  logic [DW-1:0] xu_rdata_reg, xu_rdata_next;
  logic          pq_ack_reg, pq_ack_next;
  logic          xu_ack_reg, xu_ack_next;
  logic          pq_err_reg, pq_err_next;
  logic          xu_err_reg, xu_err_next;
  logic          xu_wins;
  logic          wd_expired;

`ifdef MEM_ARB_TIMEOUT_EN
  logic wd_start;
  logic wd_clear;
  logic wd_enable;

  assign wd_start  = (state_reg == ST_IDLE) && (state_next == ST_MEM);
  assign wd_clear  = (state_reg == ST_MEM) && (state_next != ST_MEM);
  assign wd_enable = (state_reg == ST_MEM);

  mem_arb_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .start   (wd_start),
    .clear   (wd_clear),
    .enable  (wd_enable),
    .expired (wd_expired)
  );
`else
  // No watchdog: MEM waits for mem_rdy indefinitely. A non-negative limit
  // makes this constant 0; the limit only matters in the timeout build.
  assign wd_expired = (TIMEOUT < 0);
`endif

  // Next-state, grant and output-register logic for the IDLE/MEM/ACK FSM.
  always_comb begin
    state_next     = state_reg;
    grant_next     = grant_reg;
    starve_next    = starve_reg;
    mem_req_next   = mem_req_reg;
    mem_we_next    = mem_we_reg;
    mem_adr_next   = mem_adr_reg;
    mem_wdata_next = mem_wdata_reg;
    pq_rdata_next  = pq_rdata_reg;
    xu_rdata_next  = xu_rdata_reg;
    pq_ack_next    = 1'b0;
    xu_ack_next    = 1'b0;
    pq_err_next    = 1'b0;
    xu_err_next    = 1'b0;
    xu_wins        = xu_req && (!pq_req || (starve_reg < STARVE_LIM));

    case (state_reg)
      ST_IDLE: begin
        if (xu_wins) begin
          grant_next     = REQ_XU;
          mem_req_next   = 1'b1;
          mem_we_next    = xu_we;
          mem_adr_next   = xu_adr;
          mem_wdata_next = xu_wdata;
          state_next     = ST_MEM;
          if (!pq_req) begin
            starve_next = '0;
          end else if (starve_reg != STARVE_LIM) begin
            starve_next = starve_reg + 1'b1;
          end
        end else if (pq_req) begin
          grant_next   = REQ_PQ;
          mem_req_next = 1'b1;
          mem_we_next  = 1'b0;
          mem_adr_next = pq_adr;
          starve_next  = '0;
          state_next   = ST_MEM;
        end
      end
      ST_MEM: begin
        if (mem_rdy) begin
          mem_req_next = 1'b0;
          state_next   = ST_ACK;
          if (grant_reg == REQ_XU) begin
            xu_rdata_next = mem_rdata;
            xu_ack_next   = 1'b1;
          end else begin
            pq_rdata_next = mem_rdata;
            pq_ack_next   = 1'b1;
          end
        end else if (wd_expired) begin
          mem_req_next = 1'b0;
          state_next   = ST_ACK;
          if (grant_reg == REQ_XU) begin
            xu_rdata_next = '1;
            xu_ack_next   = 1'b1;
            xu_err_next   = 1'b1;
          end else begin
            pq_rdata_next = '1;
            pq_ack_next   = 1'b1;
            pq_err_next   = 1'b1;
          end
        end
      end
      ST_ACK: begin
        // The ack pulse is visible during this state; requests are not
        // sampled here, so a held request is seen on the next IDLE cycle.
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any in-flight access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      grant_reg     <= REQ_PQ;
      starve_reg    <= '0;
      mem_req_reg   <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_adr_reg   <= '0;
      mem_wdata_reg <= '0;
      pq_rdata_reg  <= '0;
      xu_rdata_reg  <= '0;
      pq_ack_reg    <= 1'b0;
      xu_ack_reg    <= 1'b0;
      pq_err_reg    <= 1'b0;
      xu_err_reg    <= 1'b0;
    end else begin
      state_reg     <= state_next;
      grant_reg     <= grant_next;
      starve_reg    <= starve_next;
      mem_req_reg   <= mem_req_next;
      mem_we_reg    <= mem_we_next;
      mem_adr_reg   <= mem_adr_next;
      mem_wdata_reg <= mem_wdata_next;
      pq_rdata_reg  <= pq_rdata_next;
      xu_rdata_reg  <= xu_rdata_next;
      pq_ack_reg    <= pq_ack_next;
      xu_ack_reg    <= xu_ack_next;
      pq_err_reg    <= pq_err_next;
      xu_err_reg    <= xu_err_next;
    end
  end

  assign mem_req   = mem_req_reg;
  assign mem_we    = mem_we_reg;
  assign mem_adr   = mem_adr_reg;
  assign mem_wdata = mem_wdata_reg;
  assign pq_ack    = pq_ack_reg;
  assign pq_rdata  = pq_rdata_reg;
  assign pq_err    = pq_err_reg;
  assign xu_ack    = xu_ack_reg;
  assign xu_rdata  = xu_rdata_reg;
  assign xu_err    = xu_err_reg;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter. Expected transactions are queued
// when stimulus is driven; a memory responder checks the bus side and an
// ack monitor checks requester-side results against the queue head.
module tb_mem_bus_arbiter;

  typedef struct {
    logic        is_xu;
    logic        we;
    logic [15:0] adr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic        err;
  } txn_t;

  logic        clk;
  logic        rst;
  logic        pq_req;
  logic [15:0] pq_adr;
  logic        pq_ack;
  logic [15:0] pq_rdata;
  logic        pq_err;
  logic        xu_req;
  logic        xu_we;
  logic [15:0] xu_adr;
  logic [15:0] xu_wdata;
  logic        xu_ack;
  logic [15:0] xu_rdata;
  logic        xu_err;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_adr;
  logic [15:0] mem_wdata;
  logic        mem_rdy;
  logic [15:0] mem_rdata;

  txn_t exp_q[$];
  txn_t mon_t;
  int   checks = 0;
  int   errors = 0;
  int   mem_lat = 1;
  logic mem_hang = 1'b0;
  int   wait_cnt = 0;

  mem_bus_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .pq_req    (pq_req),
    .pq_adr    (pq_adr),
    .pq_ack    (pq_ack),
    .pq_rdata  (pq_rdata),
    .pq_err    (pq_err),
    .xu_req    (xu_req),
    .xu_we     (xu_we),
    .xu_adr    (xu_adr),
    .xu_wdata  (xu_wdata),
    .xu_ack    (xu_ack),
    .xu_rdata  (xu_rdata),
    .xu_err    (xu_err),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_adr   (mem_adr),
    .mem_wdata (mem_wdata),
    .mem_rdy   (mem_rdy),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Memory model: mem_rdy rises mem_lat cycles after mem_req first seen.
  always @(posedge clk) begin
    #1;
    mem_rdy   = 1'b0;
    mem_rdata = 16'h0000;
    if (rst || !mem_req) begin
      wait_cnt = 0;
    end else begin
      wait_cnt++;
      if (!mem_hang && (wait_cnt == mem_lat + 1)) begin
        if (exp_q.size() == 0) begin
          check("mem_unexpected_req", {16'h0, mem_adr}, 32'hFFFF_FFFF);
        end else begin
          check("mem_we", {31'h0, mem_we}, {31'h0, exp_q[0].we});
          check("mem_adr", {16'h0, mem_adr}, {16'h0, exp_q[0].adr});
          if (exp_q[0].we) check("mem_wdata", {16'h0, mem_wdata}, {16'h0, exp_q[0].wdata});
          mem_rdata = exp_q[0].rdata;
        end
        mem_rdy = 1'b1;
      end
    end
  end

  // Ack monitor: pops the scoreboard head and checks the requester outputs.
  always @(negedge clk) begin
    if (!rst && (pq_ack || xu_ack)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_ack", {30'h0, pq_ack, xu_ack}, 32'h0);
      end else begin
        mon_t = exp_q.pop_front();
        check("ack_sel", {30'h0, pq_ack, xu_ack}, mon_t.is_xu ? 32'h1 : 32'h2);
        check("rdata", {16'h0, (mon_t.is_xu ? xu_rdata : pq_rdata)}, {16'h0, mon_t.rdata});
        check("err", {31'h0, (mon_t.is_xu ? xu_err : pq_err)}, {31'h0, mon_t.err});
        $display("ack %s adr=%04h rdata=%04h err=%0d", mon_t.is_xu ? "XU" : "PQ",
                 mon_t.adr, mon_t.is_xu ? xu_rdata : pq_rdata, mon_t.is_xu ? xu_err : pq_err);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed no finish expected finish");
    $fatal(1, "time limit");
  end

  task automatic push_txn(input logic is_xu, input logic we, input logic [15:0] adr,
                          input logic [15:0] wdata, input logic [15:0] rdata, input logic err);
    txn_t t;
    t.is_xu = is_xu; t.we = we; t.adr = adr; t.wdata = wdata; t.rdata = rdata; t.err = err;
    exp_q.push_back(t);
  endtask

  // Single access: returns the cycle (request cycle = 0) on which ack was seen.
  task automatic run_access(input logic is_xu, input logic we, input logic [15:0] adr,
                            input logic [15:0] wdata, input logic [15:0] rdata,
                            input int lat, input logic hang, input logic err, output int ack_cyc);
    push_txn(is_xu, we, adr, wdata, rdata, err);
    mem_lat = lat;
    mem_hang = hang;
    @(posedge clk); #1;
    if (is_xu) begin
      xu_req = 1'b1; xu_we = we; xu_adr = adr; xu_wdata = wdata;
    end else begin
      pq_req = 1'b1; pq_adr = adr;
    end
    ack_cyc = -1;
    for (int c = 0; c <= 60; c++) begin
      @(negedge clk);
      if (c == 0) check("mem_req_c0", {31'h0, mem_req}, 32'h0);
      if (c == 1) begin
        check("mem_req_c1", {31'h0, mem_req}, 32'h1);
        check("mem_adr_c1", {16'h0, mem_adr}, {16'h0, adr});
        check("mem_we_c1", {31'h0, mem_we}, {31'h0, is_xu & we});
      end
      if (is_xu ? xu_ack : pq_ack) begin
        ack_cyc = c;
        if (!is_xu) check("xu_ack_quiet", {31'h0, xu_ack}, 32'h0);
        break;
      end
    end
    if (is_xu) xu_req = 1'b0; else pq_req = 1'b0;
    mem_hang = 1'b0;
  endtask

  // Asserts rst between clock edges and checks the outputs clear at once.
  task automatic apply_async_reset();
    int acks;
    @(posedge clk); #2;
    check("pre_rst_mem_req", {31'h0, mem_req}, 32'h1);
    #1 rst = 1'b1;
    #1;
    check("rst_mem_req", {31'h0, mem_req}, 32'h0);
    check("rst_mem_adr", {16'h0, mem_adr}, 32'h0);
    check("rst_xu_rdata", {16'h0, xu_rdata}, 32'h0);
    xu_req = 1'b0; pq_req = 1'b0; mem_hang = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    acks = 0;
    repeat (5) begin
      @(negedge clk);
      if (pq_ack || xu_ack || mem_req) acks++;
    end
    check("no_ack_after_rst", acks, 0);
    $display("async reset applied mid-access");
  endtask

  initial begin
    int cyc;
    int n;
    int hi_cnt;
    int err_cnt;
    rst = 1'b1;
    pq_req = 1'b0; pq_adr = '0;
    xu_req = 1'b0; xu_we = 1'b0; xu_adr = '0; xu_wdata = '0;
    mem_rdy = 1'b0; mem_rdata = '0;

    // Reset state
    @(posedge clk); @(negedge clk);
    check("reset_mem_req", {31'h0, mem_req}, 32'h0);
    check("reset_acks", {28'h0, pq_ack, xu_ack, pq_err, xu_err}, 32'h0);
    check("reset_mem_bus", {mem_adr, mem_wdata}, 32'h0);
    check("reset_rdata", {pq_rdata, xu_rdata}, 32'h0);
    $display("reset state checked");
    @(posedge clk); #3 rst = 1'b0;

    // PQ read, memory answers two cycles after mem_req
    run_access(1'b0, 1'b0, 16'h0040, 16'h0000, 16'hBEEF, 2, 1'b0, 1'b0, cyc);
    check("pq_ack_latency", cyc, 4);
    $display("PQ read adr=0040 ack_cycle=%0d", cyc);

    // XU write
    run_access(1'b1, 1'b1, 16'h1234, 16'h5A5A, 16'h0F0F, 1, 1'b0, 1'b0, cyc);
    check("xu_ack_latency", cyc, 3);
    $display("XU write adr=1234 ack_cycle=%0d", cyc);

    // XU read, zero-latency memory
    run_access(1'b1, 1'b0, 16'h00F0, 16'h0000, 16'h7E57, 0, 1'b0, 1'b0, cyc);
    check("xu_read_latency", cyc, 2);
    check("pq_rdata_held", {16'h0, pq_rdata}, 32'hBEEF);
    $display("XU read adr=00F0 ack_cycle=%0d", cyc);

    // Both requesters held: XU,XU,XU,PQ,XU,XU,XU,PQ
    for (int i = 0; i < 8; i++) begin
      if (i % 4 == 3) push_txn(1'b0, 1'b0, 16'h0100, 16'h0000, 16'h1000 + 16'(i), 1'b0);
      else            push_txn(1'b1, 1'b0, 16'h2000, 16'h0000, 16'h1000 + 16'(i), 1'b0);
    end
    mem_lat = 1;
    @(posedge clk); #1;
    pq_req = 1'b1; pq_adr = 16'h0100;
    xu_req = 1'b1; xu_we = 1'b0; xu_adr = 16'h2000; xu_wdata = 16'h0000;
    n = 0;
    for (int c = 0; c < 80 && n < 8; c++) begin
      @(negedge clk);
      if (pq_ack || xu_ack) n++;
    end
    pq_req = 1'b0; xu_req = 1'b0;
    check("starve_ack_count", n, 8);
    $display("contention run acks=%0d", n);

    // Request dropped while pending still completes
    push_txn(1'b1, 1'b0, 16'h3000, 16'h0000, 16'hC0DE, 1'b0);
    mem_lat = 2;
    @(posedge clk); #1;
    xu_req = 1'b1; xu_we = 1'b0; xu_adr = 16'h3000;
    @(posedge clk); #1;
    xu_req = 1'b0;
    n = 0;
    for (int c = 0; c < 20 && n == 0; c++) begin
      @(negedge clk);
      if (xu_ack) n++;
    end
    check("dropped_req_ack", n, 1);
    $display("dropped request completed acks=%0d", n);

`ifdef MEM_ARB_TIMEOUT_EN
    // Memory never answers: watchdog aborts with all-ones data and err
    run_access(1'b1, 1'b0, 16'h5555, 16'h0000, 16'hFFFF, 0, 1'b1, 1'b1, cyc);
    check("timeout_ack_cycle", cyc, 16);
    $display("timeout abort ack_cycle=%0d", cyc);
`else
    // Memory never answers: mem_req stays up, no err ever
    mem_hang = 1'b1;
    @(posedge clk); #1;
    xu_req = 1'b1; xu_we = 1'b0; xu_adr = 16'h5555;
    hi_cnt = 0; err_cnt = 0;
    for (int c = 0; c <= 40; c++) begin
      @(negedge clk);
      if (c >= 1 && mem_req) hi_cnt++;
      if (pq_err || xu_err || xu_ack) err_cnt++;
    end
    check("hang_mem_req_held", hi_cnt, 40);
    check("hang_no_err", err_cnt, 0);
    $display("hung access mem_req_cycles=%0d", hi_cnt);
    apply_async_reset();
`endif

    // Async reset mid-MEM, then a normal access
    mem_hang = 1'b1;
    @(posedge clk); #1;
    xu_req = 1'b1; xu_we = 1'b1; xu_adr = 16'h6666; xu_wdata = 16'h1111;
    n = 0;
    for (int c = 0; c < 10 && n == 0; c++) begin
      @(negedge clk);
      if (mem_req) n++;
    end
    check("rst_test_mem_req_seen", n, 1);
    @(posedge clk);
    apply_async_reset();
    run_access(1'b0, 1'b0, 16'h0080, 16'h0000, 16'hA11C, 1, 1'b0, 1'b0, cyc);
    check("post_rst_latency", cyc, 3);
    $display("post-reset PQ read ack_cycle=%0d", cyc);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single memory bus between two requesters: the prefetch queue (PQ) for instruction fetch and the execution unit (XU) for data load/store.
- Sits between the PQ/XU and the memory interface.
- XU has priority. A starvation counter guarantees PQ forward progress so the decoder never stalls indefinitely behind back-to-back data traffic.
- One transaction is in flight at a time. All outputs are registered.

Parameters:
- AW, 16, address width
- DW, 16, data width
- STARVE_MAX, 3, number of consecutive XU grants, taken while PQ is waiting, before PQ is forced to win
- TIMEOUT, 15, watchdog limit in cycles (used only with MEM_ARB_TIMEOUT_EN)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- pq_req  in  1  PQ requests a read
- pq_adr  in  AW  PQ fetch address
- pq_ack  out  1  one-cycle pulse; pq_rdata valid this cycle
- pq_rdata  out  DW  fetched word
- pq_err  out  1  valid with pq_ack; access timed out
- xu_req  in  1  XU requests an access
- xu_we  in  1  1 = write, 0 = read
- xu_adr  in  AW  XU address
- xu_wdata  in  DW  XU write data
- xu_ack  out  1  one-cycle pulse; xu_rdata valid this cycle on reads
- xu_rdata  out  DW  read data
- xu_err  out  1  valid with xu_ack; access timed out
- mem_req  out  1  memory access strobe, held until mem_rdy
- mem_we  out  1  write enable
- mem_adr  out  AW  memory address
- mem_wdata  out  DW  write data
- mem_rdy  in  1  memory has completed the access; mem_rdata valid
- mem_rdata  in  DW  read data

Behaviour:
- Reset (async, any state): state = IDLE; mem_req, mem_we, all ack and err outputs = 0; mem_adr, mem_wdata, pq_rdata, xu_rdata = 0; starve counter = 0. Reset mid-transaction drops mem_req immediately, and the in-flight access is abandoned with no ack.
- Requester contract: hold req, adr, we and wdata stable from assertion until ack. The requester may keep req high through ack to request the next access.
- FSM states: IDLE, MEM, ACK.
- IDLE transitions:
  - If neither request is pending, stay in IDLE.
  - Otherwise grant one requester, latch its adr/we/wdata onto the mem_* outputs, set mem_req = 1, and go to MEM.
  - Grant rule: XU wins if xu_req and (!pq_req or starve < STARVE_MAX). Otherwise PQ wins.
  - PQ accesses always drive mem_we = 0.
- MEM: hold the mem_* outputs. On mem_rdy:
  - mem_req <= 0.
  - Capture mem_rdata into the granted requester's rdata register.
  - Go to ACK.
- ACK: pulse the granted requester's ack for exactly one cycle, then go to IDLE. Requests are not sampled in ACK, so a request still high during its own ack is evaluated on the next IDLE cycle.
- Starve counter:
  - XU grant while pq_req is high: increment, saturating at STARVE_MAX.
  - PQ grant: reset to 0.
  - XU grant with pq_req low: reset to 0.
- Latency:
  - Request seen in IDLE at cycle 0 → mem_req high at cycle 1.
  - mem_rdy at cycle k (k ≥ 1) → ack at cycle k+1.
  - Minimum 3 cycles per access; back-to-back throughput is 1 access per (memory latency + 2) cycles.
- Simultaneous requests with starve < STARVE_MAX: XU wins. With starve == STARVE_MAX: PQ wins.
- A request deasserted while pending, which is a protocol violation, must not corrupt state. The transaction still completes and the ack still fires.
- Data outputs are held between acks. The ungranted requester's outputs are unchanged.

Optional Feature:
- Macro: MEM_ARB_TIMEOUT_EN.
- With the macro defined:
  - A cycle counter runs in MEM.
  - If mem_rdy is absent for TIMEOUT cycles, drop mem_req, load rdata with all ones, and go to ACK with err = 1.
  - The counter clears on entering MEM.
- Without the macro: no counter; MEM waits indefinitely; pq_err and xu_err are tied to 0; the ports still exist.

Decomposition:
- Shared package: state encodings (IDLE/MEM/ACK), requester ID encoding (PQ = 0, XU = 1), default AW/DW.
- Sub-module mem_arb_watchdog: the timeout counter, with inputs start/clear/enable and a single expired output. It is instantiated only under MEM_ARB_TIMEOUT_EN.

Test Plan:
- PQ read only: pq_adr = 0x0040, memory returns 0xBEEF after 2 cycles → mem_req at cycle 1, pq_ack at cycle 4 with pq_rdata = 0xBEEF, xu_ack never asserted.
- XU write: xu_we = 1, xu_adr = 0x1234, xu_wdata = 0x5A5A → mem_we = 1, mem_adr = 0x1234, mem_wdata = 0x5A5A until mem_rdy; xu_ack pulses once.
- Both held continuously, STARVE_MAX = 3, memory latency 1 → grant order XU, XU, XU, PQ, XU, XU, XU, PQ; starve counter returns to 0 after each PQ grant.
- Async rst asserted mid-MEM → mem_req drops the same cycle without a clock edge; after release, no ack for the abandoned access; the next request is served normally.
- With MEM_ARB_TIMEOUT_EN and mem_rdy tied 0 → after 15 MEM cycles xu_ack = 1, xu_err = 1, xu_rdata = 0xFFFF; the FSM returns to IDLE.
- Without the macro, same stimulus → mem_req stays high indefinitely; err outputs are never 1.
